// File: rtl/aud_mem_pkg.sv
// Shared types for the audio SRAM arbiter: FSM states, requester ids, default widths.
package aud_mem_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int N_REQ      = 3;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  typedef enum logic [1:0] {REQ_REC, REQ_PLY, REQ_HOST} req_id_t;

endpackage

// File: rtl/aud_arb_pick.sv
// Combinational fixed-priority selector (recorder > player > host) with host promotion.
module aud_arb_pick
  import aud_mem_pkg::*;
(
  input  logic             rec_req,
  input  logic             ply_req,
  input  logic             host_req,
  input  logic             host_promote,
  output logic [N_REQ-1:0] win
);

  always_comb begin
    win = '0;
    if (host_promote && host_req) win[int'(REQ_HOST)] = 1'b1;
    else if (rec_req)             win[int'(REQ_REC)]  = 1'b1;
    else if (ply_req)             win[int'(REQ_PLY)]  = 1'b1;
    else if (host_req)            win[int'(REQ_HOST)] = 1'b1;
  end

endmodule

// File: rtl/aud_sram_arbiter.sv
// Single-port audio SRAM controller/arbiter for recorder, player and host ports.
// Optional statistics (recorder worst-case wait) enabled by AUD_SRAM_ARB_STATS_EN.
//
// state    | meaning
// S_IDLE   | strobes idle, arbitrate and latch winner
// S_SETUP  | ce_n low, address (and write data) set up
// S_ACCESS | we_n or oe_n low for ACC_CYC cycles
// S_DONE   | strobes released, address held, winner's done pulse
module aud_sram_arbiter
  import aud_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ACC_CYC    = 2,
  parameter int STARVE_MAX = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rec_req,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_wdata,
  output logic              o_rec_done,
  input  logic              i_ply_req,
  input  logic [ADDR_W-1:0] i_ply_addr,
  output logic              o_ply_done,
  output logic [DATA_W-1:0] o_ply_rdata,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_done,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_wdata_en,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n
`ifdef AUD_SRAM_ARB_STATS_EN
  ,
  input  logic              i_stat_clr,
  output logic [7:0]        o_rec_wait_max
`endif
);

  state_t            state;
  req_id_t           cur_id;
  logic              cur_we;
  logic [3:0]        acc_cnt;
  logic [7:0]        host_wait;
  logic              host_promote;
  logic [N_REQ-1:0]  win;
  req_id_t           pick_id;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic              host_win_now;
  logic              host_in_service;

  assign host_promote    = (host_wait >= 8'(STARVE_MAX));
  assign host_win_now    = (state == S_IDLE) && win[int'(REQ_HOST)];
  assign host_in_service = (state != S_IDLE) && (cur_id == REQ_HOST);

  aud_arb_pick u_pick (
    .rec_req      (i_rec_req),
    .ply_req      (i_ply_req),
    .host_req     (i_host_req),
    .host_promote (host_promote),
    .win          (win)
  );

  always_comb begin
    pick_id    = REQ_REC;
    pick_we    = 1'b1;
    pick_addr  = i_rec_addr;
    pick_wdata = i_rec_wdata;
    if (win[int'(REQ_PLY)]) begin
      pick_id    = REQ_PLY;
      pick_we    = 1'b0;
      pick_addr  = i_ply_addr;
      pick_wdata = '0;
    end else if (win[int'(REQ_HOST)]) begin
      pick_id    = REQ_HOST;
      pick_we    = i_host_we;
      pick_addr  = i_host_addr;
      pick_wdata = i_host_wdata;
    end
  end

  // Host is not "waiting" while its own access is in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                          host_wait <= '0;
    else if (!i_host_req || host_win_now || host_in_service) host_wait <= '0;
    else if (host_wait != 8'hFF)                           host_wait <= host_wait + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      cur_id          <= REQ_REC;
      cur_we          <= 1'b0;
      acc_cnt         <= '0;
      o_sram_addr     <= '0;
      o_sram_wdata    <= '0;
      o_sram_wdata_en <= 1'b0;
      o_sram_ce_n     <= 1'b1;
      o_sram_we_n     <= 1'b1;
      o_sram_oe_n     <= 1'b1;
      o_rec_done      <= 1'b0;
      o_ply_done      <= 1'b0;
      o_host_done     <= 1'b0;
      o_ply_rdata     <= '0;
      o_host_rdata    <= '0;
    end else begin
      o_rec_done  <= 1'b0;
      o_ply_done  <= 1'b0;
      o_host_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|win) begin
            state           <= S_SETUP;
            cur_id          <= pick_id;
            cur_we          <= pick_we;
            o_sram_addr     <= pick_addr;
            o_sram_wdata    <= pick_wdata;
            o_sram_wdata_en <= pick_we;
            o_sram_ce_n     <= 1'b0;
          end
        end
        S_SETUP: begin
          state       <= S_ACCESS;
          acc_cnt     <= 4'(ACC_CYC - 1);
          o_sram_we_n <= !cur_we;
          o_sram_oe_n <= cur_we;
        end
        S_ACCESS: begin
          if (acc_cnt == 4'd0) begin
            state       <= S_DONE;
            o_sram_we_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_rec_done  <= (cur_id == REQ_REC);
            o_ply_done  <= (cur_id == REQ_PLY);
            o_host_done <= (cur_id == REQ_HOST);
            if (!cur_we && cur_id == REQ_PLY)  o_ply_rdata  <= i_sram_rdata;
            if (!cur_we && cur_id == REQ_HOST) o_host_rdata <= i_sram_rdata;
          end else begin
            acc_cnt <= acc_cnt - 4'd1;
          end
        end
        S_DONE: begin
          state           <= S_IDLE;
          o_sram_ce_n     <= 1'b1;
          o_sram_wdata_en <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AUD_SRAM_ARB_STATS_EN
  logic [7:0] rec_wait;
  logic       rec_wait_act;

  // rec_wait counts cycles from the first cycle req is seen up to the done cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rec_wait       <= '0;
      rec_wait_act   <= 1'b0;
      o_rec_wait_max <= '0;
    end else begin
      if (o_rec_done) begin
        rec_wait_act <= 1'b0;
      end else if (rec_wait_act) begin
        if (rec_wait != 8'hFF) rec_wait <= rec_wait + 8'd1;
      end else if (i_rec_req) begin
        rec_wait_act <= 1'b1;
        rec_wait     <= 8'd1;
      end
      if (i_stat_clr)                                    o_rec_wait_max <= '0;
      else if (o_rec_done && rec_wait > o_rec_wait_max) o_rec_wait_max <= rec_wait;
    end
  end
`endif

endmodule

// File: doc/aud_sram_arbiter.md
# aud_sram_arbiter

Single-port SRAM controller and arbiter that shares the external 20-bit × 16-bit audio SRAM between three requesters: the audio recorder (writes), the audio player (reads) and the host/loader port (reads or writes). It serialises accesses, generates SRAM strobes with address setup and hold, and returns per-port completion pulses and read data. It sits between the audio datapath blocks and the SRAM pins, in the i_clk domain.

## Interface
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width
- ACC_CYC, 2, cycles strobe (we_n/oe_n) held low per access; legal 1..15
- STARVE_MAX, 64, host wait cycles before host is promoted to top priority; legal 1..255
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rec_req, i_rec_addr[ADDR_W], i_rec_wdata[DATA_W]  in  recorder write request
- o_rec_done  out  1  recorder write complete pulse
- i_ply_req, i_ply_addr[ADDR_W]  in  player read request
- o_ply_done  out  1; o_ply_rdata  out  DATA_W  player read complete / data
- i_host_req, i_host_we, i_host_addr[ADDR_W], i_host_wdata[DATA_W]  in  host request
- o_host_done  out  1; o_host_rdata  out  DATA_W  host complete / read data
- o_sram_addr  out  ADDR_W; o_sram_wdata  out  DATA_W; o_sram_wdata_en  out  1 (pad output enable)
- i_sram_rdata  in  DATA_W
- o_sram_ce_n, o_sram_we_n, o_sram_oe_n  out  1  active-low strobes

## Operation
- Requester holds req, addr, wdata, we stable until its done pulse; it drops req on the cycle after done, or keeps it high with the next transaction's fields already presented.
- FSM: S_IDLE → S_SETUP → S_ACCESS → S_DONE → S_IDLE.
- S_IDLE: if any req is high, pick a winner, latch its id/addr/wdata/we, go to S_SETUP. Otherwise stay.
- Priority: recorder > player > host. Override: host wait counter increments each cycle host_req is high and the host is not the winner. At count ≥ STARVE_MAX, host wins the next arbitration. Counter clears when host wins or when host_req is low.
- S_SETUP (1 cycle): ce_n=0, address driven. For writes, wdata_en=1.
- S_ACCESS (ACC_CYC cycles, down-counter): writes drive we_n=0; reads drive oe_n=0. On the last read cycle, capture i_sram_rdata into the winner's rdata register.
- S_DONE (1 cycle): strobes high, ce_n=0, address and wdata_en held (hold time). The winner's done is high for exactly this cycle.
- rdata registers hold their value until that port's next read completes.
- No requests are lost. Requests arriving outside S_IDLE wait.

## Timing
- Reset values: addr=0, wdata=0, wdata_en=0, ce_n=we_n=oe_n=1, all done=0, all rdata=0, state=S_IDLE, wait counter=0.
- Reset mid-access: strobes deassert immediately (asynchronously). The in-flight transaction is dropped, with no done pulse.
- Latency: request sampled in S_IDLE at edge 0 → done high in cycle 2+ACC_CYC. Throughput is one access per 3+ACC_CYC cycles (5 with the defaults).
- All outputs are registered. we_n/oe_n are never low in S_SETUP or S_DONE.
- Simultaneous requests from all three ports: the recorder is served first, then the player, then the host (unless the host is promoted).

## Configuration
- AUD_SRAM_ARB_STATS_EN defined: adds input i_stat_clr and output o_rec_wait_max[8]. This is the maximum number of cycles between i_rec_req rise and o_rec_done, saturating at 255. It is cleared by i_stat_clr or by reset.
- Undefined: those ports and their logic are absent. Arbitration behaviour is identical.

## Structure
- Package aud_mem_pkg: ADDR_W/DATA_W defaults, state enum (S_IDLE, S_SETUP, S_ACCESS, S_DONE), requester id enum (REQ_REC, REQ_PLY, REQ_HOST).
- Sub-module aud_arb_pick: combinational priority selector. Inputs are the three reqs and the host-promote flag. Output is a one-hot winner.

## Test plan
- Recorder write addr 0x00010 data 0xA5A5, ACC_CYC=2 → we_n low in cycles 2–3, o_rec_done in cycle 4, SRAM model holds 0xA5A5.
- Player read of 0x00010 after the above → o_ply_done in cycle 4, o_ply_rdata=0xA5A5, oe_n low 2 cycles, we_n never low.
- All three reqs rise together → done order: rec, ply, host, at cycles 4, 9, 14.
- Recorder and player requesting continuously, host held, STARVE_MAX=8 → host served within 8+5 cycles of promotion; counter resets.
- Assert i_rst_n low during S_ACCESS of a write → ce_n/we_n high asynchronously, no done, FSM in S_IDLE after release.
- With AUD_SRAM_ARB_STATS_EN: recorder blocked behind a host access → o_rec_wait_max equals the measured wait; i_stat_clr → 0.
